// File: rtl/mult_seq.sv
// Sequential shift-add multiplier with signed/unsigned mode.
// One accumulate-and-shift step per clock over WIDTH cycles, then a
// sign-fix cycle that loads the 2*WIDTH-bit product into HI/LO.
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     mcnd_q;
    logic [WIDTH-1:0]     mplr_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic [WIDTH-1:0]     a_mag_d;
    logic [WIDTH-1:0]     b_mag_d;
    logic                 neg_d;
    logic [WIDTH:0]       sum_d;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   prod_d;
    logic                 cnt_last_d;
    logic                 accept_d;

    // Operand capture, one shift-add step and final sign fix-up
    always_comb begin
        a_mag_d    = (signed_i && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
        b_mag_d    = (signed_i && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;
        neg_d      = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        // Upper half plus multiplicand keeps its carry in bit WIDTH
        sum_d      = mplr_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcnd_q})
                               : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        acc_d      = {sum_d, acc_q[WIDTH-1:1]};
        prod_d     = neg_q ? (~acc_q + 1'b1) : acc_q;
        cnt_last_d = (cnt_q == CNT_W'(WIDTH - 1));
        accept_d   = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // Control FSM with registered BUSY/DONE/HI/LO
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            mcnd_q  <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (accept_d) begin
                        mcnd_q  <= a_mag_d;
                        mplr_q  <= b_mag_d;
                        neg_q   <= neg_d;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_q  <= acc_d;
                    mplr_q <= mplr_q >> 1;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_last_d) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_q    <= prod_d[2*WIDTH-1:WIDTH];
                    lo_q    <= prod_d[WIDTH-1:0];
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: cycle-level behavioural model for the
// 32-bit instance, directed literal cases, and an 8-bit instance.
module tb_mult_seq;

    localparam int W  = 32;
    localparam int W8 = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        start8 = 1'b0;
    logic        sgn8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    mult_seq #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .signed_i(sgn),
        .a_i(a), .b_i(b), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    mult_seq #(.WIDTH(W8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .signed_i(sgn8),
        .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8), .hi_o(hi8), .lo_o(lo8)
    );

    // Exact product: extend both operands to 2W bits and multiply
    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = s ? {{32{x[31]}}, x} : {32'b0, x};
        ye = s ? {{32{y[31]}}, y} : {32'b0, y};
        return xe * ye;
    endfunction

    function automatic logic [15:0] ref8(input logic s, input logic [7:0] x, input logic [7:0] y);
        logic [15:0] xe;
        logic [15:0] ye;
        xe = s ? {{8{x[7]}}, x} : {8'b0, x};
        ye = s ? {{8{y[7]}}, y} : {8'b0, y};
        return xe * ye;
    endfunction

    // Behavioural model: a request is accepted when not busy, the result
    // appears WIDTH+1 edges later together with a one-cycle DONE.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_pend = '0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_busy <= (m_left > 1);
            if (m_left == 1) begin
                m_hi   <= m_pend[63:32];
                m_lo   <= m_pend[31:0];
                m_done <= 1'b1;
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_pend <= ref_prod(sgn, a, b);
                m_left <= W + 1;
                m_busy <= 1'b1;
            end else begin
                m_busy <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("busy", 64'(busy), 64'(m_busy));
                chk("done", 64'(done), 64'(m_done));
                chk("hi", 64'(hi), 64'(m_hi));
                chk("lo", 64'(lo), 64'(m_lo));
                chk("busy_and_done", 64'(busy & done), 64'd0);
            end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One 32-bit operation; optionally re-pulses START with junk at cycle rp
    task automatic run32(input string nm, input logic s, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo, input int rp);
        int k;
        int bc;
        @(negedge clk);
        start = 1'b1; sgn = s; a = x; b = y;
        k = 0; bc = 0;
        do begin
            @(negedge clk);
            k++;
            if (busy) bc++;
            start = (k == rp);
            a = $urandom; b = $urandom; sgn = 1'($urandom);
        end while (!done && k < 100);
        start = 1'b0;
        chk({nm, "_latency"}, 64'(k), 64'd34);
        chk({nm, "_busy_cycles"}, 64'(bc), 64'd33);
        chk({nm, "_hi"}, 64'(hi), 64'(ehi));
        chk({nm, "_lo"}, 64'(lo), 64'(elo));
        $display("op32 %s s=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", nm, s, x, y, hi, lo, k);
    endtask

    task automatic run8(input string nm, input logic s, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp);
        int k;
        @(negedge clk);
        start8 = 1'b1; sgn8 = s; a8 = x; b8 = y;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            start8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom);
        end while (!done8 && k < 40);
        chk({nm, "_latency"}, 64'(k), 64'd10);
        chk({nm, "_hi"}, 64'(hi8), 64'(exp[15:8]));
        chk({nm, "_lo"}, 64'(lo8), 64'(exp[7:0]));
        $display("op8 %s s=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", nm, s, x, y, hi8, lo8, k);
    endtask

    initial begin
        int d1;
        int d2;
        int k;
        logic [7:0]  x8;
        logic [7:0]  y8;
        logic        s8;
        fork
            compare_loop();
        join_none

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy8", 64'(busy8), 64'd0);
        cmp_en = 1'b1;
        rst_n = 1'b1;

        // Hand-computed values that pin the reference model itself
        chk("model_pin_neg", ref_prod(1'b1, 32'hFFFF_FFFF, 32'h1), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_pin_min", ref_prod(1'b1, 32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
        chk("model_pin_u", ref_prod(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);

        run32("u9x8", 1'b0, 32'd9, 32'd8, 32'h0, 32'h48, 0);
        run32("uff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 0);
        run32("sff", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 0);
        run32("sm1x1", 1'b1, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run32("smin", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0);
        run32("repulse", 1'b0, 32'd9, 32'd8, 32'h0, 32'h48, 5);

        // START held high: back-to-back operations with no idle cycle
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 32'd3; b = 32'd5;
        d1 = -1; d2 = -1; k = 0;
        while (k < 120 && d2 < 0) begin
            @(negedge clk);
            k++;
            if (done) begin
                if (d1 < 0) begin
                    d1 = k;
                    chk("b2b_first_lo", 64'(lo), 64'd15);
                end else begin
                    d2 = k;
                end
            end
            a = pick(); b = pick(); sgn = 1'($urandom);
        end
        start = 1'b0;
        chk("b2b_gap", 64'(d2 - d1), 64'd34);
        $display("b2b done at %0d and %0d", d1, d2);
        repeat (40) @(negedge clk);

        // Asynchronous reset 10 cycles into CALC
        run32("u7x6", 1'b0, 32'd7, 32'd6, 32'h0, 32'd42, 0);
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        $display("async reset mid-CALC: busy=%0d done=%0d hi=%h lo=%h", busy, done, hi, lo);
        @(negedge clk);
        rst_n = 1'b1;
        run32("u3x5", 1'b0, 32'd3, 32'd5, 32'h0, 32'hF, 0);

        // Randomised traffic, checked every cycle against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            sgn = 1'($urandom);
            a = pick();
            b = pick();
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        // 8-bit instance
        run8("w8_min_x_max", 1'b1, 8'h80, 8'h7F, 16'hC080);
        for (int i = 0; i < 12; i++) begin
            x8 = 8'($urandom);
            y8 = 8'($urandom);
            s8 = 1'($urandom);
            run8("w8_rand", s8, x8, y8, ref8(s8, x8, y8));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
# mult_seq

Parametrised sequential multiplier with signed/unsigned mode and a start/done handshake. It is the iterative successor to the 32-bit combinational MULT32: same HI/LO result split, but with a generic operand width and one shift-add step per clock, trading latency for area. It sits beside the ALU and is driven by the control unit, which stalls on BUSY.

## Interface
- WIDTH, 32, operand width in bits; legal values are 2 or more; result is 2*WIDTH bits split across HI/LO.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; asynchronous, active-low.
- START  input  1  request; sampled only when BUSY=0.
- SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; captured with START.
- A  input  WIDTH  multiplicand (MCND); captured with START.
- B  input  WIDTH  multiplier (MPLR); captured with START.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse; HI/LO are valid from this cycle onward.
- HI  output  WIDTH  upper WIDTH bits of the product.
- LO  output  WIDTH  lower WIDTH bits of the product.

## Operation
- Reset values: state IDLE; BUSY=0, DONE=0, HI=0, LO=0; internal counter and registers are cleared.
- States are IDLE, CALC, FIX and DONE.
- IDLE / DONE, when START=1:
  - Capture |A| and |B|, using magnitudes only if SIGNED=1, otherwise the raw values.
  - Set neg = SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]).
  - Clear the 2*WIDTH accumulator and the counter, then go to CALC.
- IDLE / DONE, when START=0: go to or stay in IDLE.
- CALC runs exactly WIDTH cycles. Each cycle:
  - If multiplier bit 0 = 1, add the multiplicand (zero-extended) into the upper half of the accumulator, with carry kept.
  - Shift the accumulator and the multiplier right by one.
  - Increment the counter.
  - After the WIDTH-th step, go to FIX.
- FIX:
  - Load {HI,LO} with the accumulator, two's-complement negated over 2*WIDTH bits if neg=1.
  - Go to DONE.
- DONE: DONE=1 for exactly this cycle. START is accepted here, which allows back-to-back operations.
- Magnitude of the most negative value (e.g. 0x80000000) is representable as an unsigned WIDTH-bit value; no overflow is possible. The full 2*WIDTH product is always exact.
- HI/LO hold their value until the next FIX; they do not change during CALC.
- START, A, B and SIGNED are ignored while BUSY=1. Operands may change freely after capture.
- Reset asserted mid-operation aborts the operation: all outputs return to reset values immediately (asynchronously), and no DONE pulse is produced.

## Timing
- BUSY=1 in CALC and FIX; BUSY=0 in IDLE and DONE.
- START sampled at edge t0 gives BUSY=1 from t0 through t0+WIDTH+1.
- HI/LO update at edge t0+WIDTH+1.
- DONE=1 in the cycle following edge t0+WIDTH+1; total latency is WIDTH+2 cycles from START to DONE.
- Throughput is one result per WIDTH+2 cycles when START is held high continuously.
- DONE and BUSY are never both high.

## Test plan
- Reset, then WIDTH=32, SIGNED=0, A=9, B=8, START pulse -> BUSY for 33 cycles, DONE in cycle 34, HI=0x00000000, LO=0x00000048.
- SIGNED=0, A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. The same operands with SIGNED=1 (-1*-1) -> HI=0x00000000, LO=0x00000001.
- SIGNED=1, A=0xFFFFFFFF, B=0x00000001 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF. Also SIGNED=1, A=B=0x80000000 -> HI=0x40000000, LO=0x00000000.
- START re-pulsed with new operands mid-CALC -> ignored; the original product is returned with unchanged latency. START held high through DONE -> the second operation starts with no idle cycle.
- RST driven low 10 cycles into CALC -> BUSY, DONE, HI and LO are 0 immediately and the state is IDLE. After release, a new START with A=3, B=5 -> LO=0x0000000F.
- WIDTH=8 instance, SIGNED=1, A=0x80 (-128), B=0x7F (127) -> DONE after 10 cycles, HI=0xC0, LO=0x80 (-16256).
